// File: rtl/reg_cmd_sequencer.sv
// Micro-instruction sequencer for the X/Y/Z signed register datapath.
// Accepts one opcode per start/done handshake and emits per-register command codes.
module reg_cmd_sequencer #(
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [AMT_W-1:0] amt,
    output logic [2:0]       Tx,
    output logic [2:0]       Ty,
    output logic [2:0]       Tz,
    output logic             alu_sel,
    output logic             x_src,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] CMD_HOLD   = 3'b000;
    localparam logic [2:0] CMD_LOAD   = 3'b001;
    localparam logic [2:0] CMD_SHIFTR = 3'b010;
    localparam logic [2:0] CMD_SHIFTL = 3'b011;
    localparam logic [2:0] CMD_RESET  = 3'b100;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LDX   = 4'b0001;
    localparam logic [3:0] OP_LDY   = 4'b0010;
    localparam logic [3:0] OP_CLR   = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_SHRX  = 4'b0110;
    localparam logic [3:0] OP_SHLX  = 4'b0111;
    localparam logic [3:0] OP_MOVZX = 4'b1000;

    localparam logic [AMT_W-1:0] CNT_ZERO = '0;
    localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);

    logic [1:0]       r_state;
    logic [3:0]       r_op;
    logic [AMT_W-1:0] r_cnt;

    logic             w_is_shift;
    logic [2:0]       w_shift_cmd;

    assign w_is_shift  = (r_op == OP_SHRX) || (r_op == OP_SHLX);
    assign w_shift_cmd = (r_op == OP_SHRX) ? CMD_SHIFTR : CMD_SHIFTL;

    // r_cnt holds the number of shifts still to issue, including the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_NOP;
            r_cnt   <= CNT_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= opcode;
                        r_cnt   <= amt;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_is_shift && (r_cnt > CNT_ONE)) begin
                        r_cnt   <= r_cnt - CNT_ONE;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt <= CNT_ONE) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on registered state so reset forces them idle at once.
    always_comb begin
        Tx      = CMD_HOLD;
        Ty      = CMD_HOLD;
        Tz      = CMD_HOLD;
        alu_sel = 1'b0;
        x_src   = 1'b0;
        busy    = (r_state != S_IDLE);
        done    = 1'b0;
        err     = 1'b0;
        case (r_state)
            S_EXEC: begin
                case (r_op)
                    OP_LDX:   Tx = CMD_LOAD;
                    OP_LDY:   Ty = CMD_LOAD;
                    OP_CLR: begin
                        Tx = CMD_RESET;
                        Ty = CMD_RESET;
                        Tz = CMD_RESET;
                    end
                    OP_ADD:   Tz = CMD_LOAD;
                    OP_SUB: begin
                        Tz      = CMD_LOAD;
                        alu_sel = 1'b1;
                    end
                    OP_SHRX, OP_SHLX: begin
                        if (r_cnt != CNT_ZERO) begin
                            Tx = w_shift_cmd;
                        end
                    end
                    OP_MOVZX: begin
                        Tx    = CMD_LOAD;
                        x_src = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_SHIFT: begin
                Tx = w_shift_cmd;
            end
            S_DONE: begin
                done = 1'b1;
                err  = (r_op > OP_MOVZX);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Directed bench for reg_cmd_sequencer: hand-computed command traces per opcode.
module tb_reg_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] opcode;
    logic [1:0] amt;
    logic [2:0] Tx, Ty, Tz;
    logic       alu_sel, x_src, busy, done, err;

    int tests_run;
    int tests_failed;

    logic [2:0] tr_tx   [16];
    logic [2:0] tr_ty   [16];
    logic [2:0] tr_tz   [16];
    logic       tr_alu  [16];
    logic       tr_xsrc [16];
    logic       tr_busy [16];
    logic       tr_done [16];
    logic       tr_err  [16];

    reg_cmd_sequencer #(.AMT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .amt(amt),
        .Tx(Tx), .Ty(Ty), .Tz(Tz), .alu_sel(alu_sel), .x_src(x_src),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept one instruction, then scramble opcode/amt and record ncyc cycles;
    // index 0 is the cycle right after the accepting edge.
    task automatic issue_and_capture(input logic [3:0] op, input logic [1:0] a, input int ncyc);
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        amt    = a;
        @(posedge clk);
        #1;
        start  = 1'b0;
        opcode = 4'b0011;
        amt    = 2'd3;
        for (int k = 0; k < ncyc; k++) begin
            tr_tx[k] = Tx;  tr_ty[k] = Ty;  tr_tz[k] = Tz;
            tr_alu[k] = alu_sel; tr_xsrc[k] = x_src;
            tr_busy[k] = busy; tr_done[k] = done; tr_err[k] = err;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({Tx, Ty, Tz} !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_cmds: got %b want 000000000", {Tx, Ty, Tz});
        end
        tests_run++;
        if ({alu_sel, x_src, busy, done, err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 00000", {alu_sel, x_src, busy, done, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || Tx !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_release: busy=%b Tx=%b want 0/000", busy, Tx);
        end
    endtask

    task automatic test_single_ops();
        logic [3:0] ops   [6] = '{4'b0001, 4'b0100, 4'b0101, 4'b0010, 4'b0011, 4'b1000};
        logic [2:0] exp_x [6] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001};
        logic [2:0] exp_y [6] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b100, 3'b000};
        logic [2:0] exp_z [6] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 3'b000};
        logic       exp_a [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       exp_s [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            issue_and_capture(ops[i], 2'd0, 3);
            tests_run++;
            if ({tr_tx[0], tr_ty[0], tr_tz[0], tr_alu[0], tr_xsrc[0]} !==
                {exp_x[i], exp_y[i], exp_z[i], exp_a[i], exp_s[i]}) begin
                tests_failed++;
                $display("FAIL op%b_exec: got Tx=%b Ty=%b Tz=%b alu=%b xs=%b want %b %b %b %b %b",
                         ops[i], tr_tx[0], tr_ty[0], tr_tz[0], tr_alu[0], tr_xsrc[0],
                         exp_x[i], exp_y[i], exp_z[i], exp_a[i], exp_s[i]);
            end
            tests_run++;
            if ({tr_busy[0], tr_done[0]} !== 2'b10) begin
                tests_failed++;
                $display("FAIL op%b_exec_flags: busy,done=%b want 10", ops[i], {tr_busy[0], tr_done[0]});
            end
            tests_run++;
            if ({tr_tx[1], tr_ty[1], tr_tz[1], tr_alu[1], tr_xsrc[1], tr_busy[1], tr_done[1], tr_err[1]} !==
                {9'b0, 2'b00, 3'b110}) begin
                tests_failed++;
                $display("FAIL op%b_done: Tx=%b Ty=%b Tz=%b busy=%b done=%b err=%b want hold,1,1,0",
                         ops[i], tr_tx[1], tr_ty[1], tr_tz[1], tr_busy[1], tr_done[1], tr_err[1]);
            end
            tests_run++;
            if ({tr_busy[2], tr_done[2], tr_tx[2], tr_tz[2]} !== 8'b0) begin
                tests_failed++;
                $display("FAIL op%b_idle: busy=%b done=%b Tx=%b Tz=%b want all 0",
                         ops[i], tr_busy[2], tr_done[2], tr_tx[2], tr_tz[2]);
            end
        end
    endtask

    task automatic test_shrx3();
        logic signed [3:0] x_model;
        x_model = 4'b1000;
        issue_and_capture(4'b0110, 2'd3, 5);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (tr_tx[k] !== 3'b010 || tr_done[k] !== 1'b0 || tr_busy[k] !== 1'b1) begin
                tests_failed++;
                $display("FAIL shrx3_cyc%0d: Tx=%b done=%b busy=%b want 010/0/1", k, tr_tx[k], tr_done[k], tr_busy[k]);
            end
        end
        tests_run++;
        if (tr_tx[3] !== 3'b000 || tr_done[3] !== 1'b1 || tr_err[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL shrx3_done: Tx=%b done=%b err=%b want 000/1/0", tr_tx[3], tr_done[3], tr_err[3]);
        end
        tests_run++;
        if (tr_busy[4] !== 1'b0 || tr_tx[4] !== 3'b000) begin
            tests_failed++;
            $display("FAIL shrx3_idle: busy=%b Tx=%b want 0/000", tr_busy[4], tr_tx[4]);
        end
        for (int k = 0; k < 5; k++) begin
            if (tr_tx[k] == 3'b010) x_model = x_model >>> 1;
            else if (tr_tx[k] == 3'b011) x_model = x_model <<< 1;
        end
        tests_run++;
        if (x_model !== 4'b1111) begin
            tests_failed++;
            $display("FAIL shrx3_xreg: got %b want 1111", x_model);
        end
    endtask

    task automatic test_noop_like();
        logic [3:0] ops [2] = '{4'b0111, 4'b0000};
        for (int i = 0; i < 2; i++) begin
            issue_and_capture(ops[i], 2'd0, 3);
            tests_run++;
            if ({tr_tx[0], tr_ty[0], tr_tz[0], tr_busy[0], tr_done[0]} !== {9'b0, 2'b10}) begin
                tests_failed++;
                $display("FAIL noop%b_exec: Tx=%b Ty=%b Tz=%b busy=%b done=%b want hold,1,0",
                         ops[i], tr_tx[0], tr_ty[0], tr_tz[0], tr_busy[0], tr_done[0]);
            end
            tests_run++;
            if ({tr_tx[1], tr_done[1], tr_err[1], tr_busy[2]} !== 6'b000100) begin
                tests_failed++;
                $display("FAIL noop%b_done: Tx=%b done=%b err=%b busy_after=%b want 000/1/0/0",
                         ops[i], tr_tx[1], tr_done[1], tr_err[1], tr_busy[2]);
            end
        end
    endtask

    task automatic test_illegal();
        issue_and_capture(4'b1100, 2'd1, 3);
        tests_run++;
        if ({tr_tx[0], tr_ty[0], tr_tz[0], tr_done[0], tr_err[0], tr_busy[0]} !== {9'b0, 3'b001}) begin
            tests_failed++;
            $display("FAIL illegal_exec: Tx=%b Ty=%b Tz=%b done=%b err=%b busy=%b want hold,0,0,1",
                     tr_tx[0], tr_ty[0], tr_tz[0], tr_done[0], tr_err[0], tr_busy[0]);
        end
        tests_run++;
        if ({tr_tx[1], tr_ty[1], tr_tz[1], tr_done[1], tr_err[1]} !== {9'b0, 2'b11}) begin
            tests_failed++;
            $display("FAIL illegal_done: Tx=%b Ty=%b Tz=%b done=%b err=%b want hold,1,1",
                     tr_tx[1], tr_ty[1], tr_tz[1], tr_done[1], tr_err[1]);
        end
        tests_run++;
        if ({tr_done[2], tr_err[2], tr_busy[2]} !== 3'b000) begin
            tests_failed++;
            $display("FAIL illegal_after: done=%b err=%b busy=%b want 000", tr_done[2], tr_err[2], tr_busy[2]);
        end
    endtask

    task automatic test_start_while_busy();
        int  n_done;
        bit  saw_reset;
        n_done    = 0;
        saw_reset = 0;
        @(negedge clk);
        start = 1'b1; opcode = 4'b0111; amt = 2'd2;
        @(posedge clk);
        #1;
        opcode = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) start = 1'b0;
            if (Tx == 3'b100 || Ty == 3'b100 || Tz == 3'b100) saw_reset = 1;
            if (done === 1'b1) n_done++;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (saw_reset !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_start_no_reset: saw RESET code=%b want 0", saw_reset);
        end
        tests_run++;
        if (n_done != 1) begin
            tests_failed++;
            $display("FAIL busy_start_done_count: got %0d want 1", n_done);
        end
        issue_and_capture(4'b0010, 2'd0, 3);
        tests_run++;
        if (tr_ty[0] !== 3'b001 || tr_tx[0] !== 3'b000 || tr_done[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_start_next: Ty=%b Tx=%b done=%b want 001/000/1", tr_ty[0], tr_tx[0], tr_done[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_tx   [7] = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001};
        logic       exp_done [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        @(negedge clk);
        start = 1'b1; opcode = 4'b0001; amt = 2'd0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 7; k++) begin
            tests_run++;
            if (Tx !== exp_tx[k] || done !== exp_done[k]) begin
                tests_failed++;
                $display("FAIL b2b_cyc%0d: Tx=%b done=%b want %b/%b", k, Tx, done, exp_tx[k], exp_done[k]);
            end
            if (k < 6) begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit bad;
        bad = 0;
        @(negedge clk);
        start = 1'b1; opcode = 4'b0111; amt = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (Tx !== 3'b011) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: Tx=%b want 011", Tx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (Tx !== 3'b000 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: Tx=%b busy=%b done=%b want 000/0/0", Tx, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (Tx == 3'b011 || busy !== 1'b0 || done !== 1'b0) bad = 1;
        end
        tests_run++;
        if (bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_after: activity after release=%b want 0", bad);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        opcode = 4'b0000;
        amt    = 2'd0;
        test_reset();
        test_single_ops();
        test_shrx3();
        test_noop_like();
        test_illegal();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
